// File: rtl/watch_timer_sequencer.sv
// watch_timer_sequencer
//   Avalon-MM write-only master that programs an interval timer for a 1 ms
//   period, services each timeout by clearing the TO flag, and counts the
//   resulting ticks into hh:mm:ss.mmm watch time.
//   Optional feature macro: WATCH_ALARM_EN (adds an hh:mm alarm).
//   Handshake: the timer slave has no waitrequest, so every write completes in
//   the single cycle where chipselect=1 and write_n=0; tmr_irq is a level that
//   stays high until the TO flag is cleared by a write to address 0.
//   dbg_state exposes the FSM state encoding for checkers.
module watch_timer_sequencer #(
  parameter logic [31:0] TMR_PERIOD = 32'd49999,
  parameter logic [15:0] CTRL_RUN   = 16'h0007,
  parameter logic [15:0] CTRL_STOP  = 16'h0008
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        set_valid,
  input  logic [4:0]  set_hour,
  input  logic [5:0]  set_min,
  input  logic [5:0]  set_sec,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic        tmr_irq,
  output logic [9:0]  ms,
  output logic [5:0]  sec,
  output logic [5:0]  min,
  output logic [4:0]  hour,
  output logic        tick_1s,
  output logic [2:0]  dbg_state,
  output logic        running
`ifdef WATCH_ALARM_EN
  ,
  input  logic        alarm_set,
  input  logic [4:0]  alarm_hour,
  input  logic [5:0]  alarm_min,
  input  logic        alarm_ack,
  output logic        alarm
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_PL   = 3'd1,
    S_WR_PH   = 3'd2,
    S_WR_CTL  = 3'd3,
    S_RUN     = 3'd4,
    S_CLR     = 3'd5,
    S_WR_STOP = 3'd6
  } state_t;

  state_t      r_state;
  logic        w_ms_wrap;
  logic        w_sec_wrap;
  logic        w_min_wrap;
  logic [9:0]  w_ms_n;
  logic [5:0]  w_sec_n;
  logic [5:0]  w_min_n;
  logic [4:0]  w_hour_n;
  logic [4:0]  w_set_hour;
  logic [5:0]  w_set_min;
  logic [5:0]  w_set_sec;

  assign dbg_state = r_state;

  // Next watch time after one millisecond, with cascaded rollovers.
  always_comb begin
    w_ms_wrap  = (ms == 10'd999);
    w_sec_wrap = (sec == 6'd59);
    w_min_wrap = (min == 6'd59);
    w_ms_n     = w_ms_wrap ? 10'd0 : ms + 10'd1;
    w_sec_n    = sec;
    w_min_n    = min;
    w_hour_n   = hour;
    if (w_ms_wrap) begin
      w_sec_n = w_sec_wrap ? 6'd0 : sec + 6'd1;
      if (w_sec_wrap) begin
        w_min_n = w_min_wrap ? 6'd0 : min + 6'd1;
        if (w_min_wrap) begin
          w_hour_n = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
        end
      end
    end
  end

  // Clamp out-of-range set values to the largest legal value.
  always_comb begin
    w_set_hour = (set_hour > 5'd23) ? 5'd23 : set_hour;
    w_set_min  = (set_min  > 6'd59) ? 6'd59 : set_min;
    w_set_sec  = (set_sec  > 6'd59) ? 6'd59 : set_sec;
  end

  // Sequencer FSM with registered bus outputs, plus the watch time counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      tmr_address    <= 3'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= 16'd0;
      running        <= 1'b0;
      tick_1s        <= 1'b0;
      ms             <= 10'd0;
      sec            <= 6'd0;
      min            <= 6'd0;
      hour           <= 5'd0;
    end else begin
      // Bus idles unless the transition below enters a write state.
      tmr_address    <= 3'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= 16'd0;
      running        <= 1'b0;
      tick_1s        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state        <= S_WR_PL;
            tmr_address    <= 3'd2;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_writedata  <= TMR_PERIOD[15:0];
          end
        end
        S_WR_PL: begin
          r_state        <= S_WR_PH;
          tmr_address    <= 3'd3;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_writedata  <= TMR_PERIOD[31:16];
        end
        S_WR_PH: begin
          // Control goes last: any period write stops the timer.
          r_state        <= S_WR_CTL;
          tmr_address    <= 3'd1;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_writedata  <= CTRL_RUN;
        end
        S_WR_CTL: begin
          r_state <= S_RUN;
          running <= 1'b1;
        end
        S_RUN: begin
          // Stopping beats a pending timeout; that timeout is never counted.
          if (!run) begin
            r_state        <= S_WR_STOP;
            tmr_address    <= 3'd1;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_writedata  <= CTRL_STOP;
          end else if (tmr_irq) begin
            r_state        <= S_CLR;
            tmr_address    <= 3'd0;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_writedata  <= 16'd0;
            running        <= 1'b1;
          end else begin
            running <= 1'b1;
          end
        end
        S_CLR: begin
          r_state <= S_RUN;
          running <= 1'b1;
        end
        S_WR_STOP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      // A set load overrides a coincident millisecond tick.
      if (set_valid) begin
        hour <= w_set_hour;
        min  <= w_set_min;
        sec  <= w_set_sec;
        ms   <= 10'd0;
      end else if (r_state == S_CLR) begin
        ms      <= w_ms_n;
        sec     <= w_sec_n;
        min     <= w_min_n;
        hour    <= w_hour_n;
        tick_1s <= w_ms_wrap;
      end
    end
  end

`ifdef WATCH_ALARM_EN
  logic [4:0] r_al_hour;
  logic [5:0] r_al_min;
  logic       r_al_armed;
  logic       w_al_match;

  // Alarm fires when a counted tick lands exactly on the armed hh:mm:00.000.
  assign w_al_match = r_al_armed && !set_valid && (r_state == S_CLR) && w_ms_wrap &&
                      (w_sec_n == 6'd0) && (w_min_n == r_al_min) &&
                      (w_hour_n == r_al_hour);

  // Alarm time latch and sticky alarm flag; acknowledge has priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_al_hour  <= 5'd0;
      r_al_min   <= 6'd0;
      r_al_armed <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      if (alarm_set) begin
        r_al_hour  <= alarm_hour;
        r_al_min   <= alarm_min;
        r_al_armed <= 1'b1;
      end
      if (alarm_ack) begin
        alarm <= 1'b0;
      end else if (w_al_match) begin
        alarm <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_watch_timer_sequencer.sv
// tb_watch_timer_sequencer
//   Drives the sequencer against a behavioural interval-timer stand-in and
//   checks watch time against a milliseconds-of-day reference model.
//   Build with +define+WATCH_ALARM_EN to include the alarm scenario.
module tb_watch_timer_sequencer;
  localparam logic [31:0] PERIOD = 32'd9;
  localparam int DAY_MS = 86400000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        set_valid = 1'b0;
  logic [4:0]  set_hour = 5'd0;
  logic [5:0]  set_min = 6'd0;
  logic [5:0]  set_sec = 6'd0;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;
  logic [9:0]  ms;
  logic [5:0]  sec;
  logic [5:0]  min;
  logic [4:0]  hour;
  logic        tick_1s;
  logic [2:0]  dbg_state;
  logic        running;
`ifdef WATCH_ALARM_EN
  logic        alarm_set = 1'b0;
  logic [4:0]  alarm_hour = 5'd0;
  logic [5:0]  alarm_min = 6'd0;
  logic        alarm_ack = 1'b0;
  logic        alarm;
`endif

  int checks = 0;
  int errors = 0;
  int nprint = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  watch_timer_sequencer #(.TMR_PERIOD(PERIOD)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .set_valid(set_valid),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq),
    .ms(ms), .sec(sec), .min(min), .hour(hour), .tick_1s(tick_1s),
    .dbg_state(dbg_state), .running(running)
`ifdef WATCH_ALARM_EN
    , .alarm_set(alarm_set), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_ack(alarm_ack), .alarm(alarm)
`endif
  );

  // ---------------- interval timer stand-in ----------------
  // A period write stops the timer and, in this stand-in, also drops TO so a
  // restart begins from a clean flag.
  logic [15:0] t_pl = 16'd0, t_ph = 16'd0, t_ctl = 16'd0;
  int unsigned t_cnt = 0;
  bit t_run = 0, t_to = 0;
  bit clr_en = 0;      // sequencer is running and should service timeouts
  bit pend0 = 0, pend1 = 0;
  assign tmr_irq = t_to && t_ctl[0];

  always @(posedge clk) begin
    pend0 <= 1'b0;
    if (t_run) begin
      if (t_cnt == 0) begin
        t_to  <= 1'b1;
        t_cnt <= {t_ph, t_pl};
        pend0 <= t_ctl[0] && clr_en;
        if (!t_ctl[1]) t_run <= 1'b0;
      end else begin
        t_cnt <= t_cnt - 1;
      end
    end
    if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: t_to <= 1'b0;
        3'd1: begin
          t_ctl <= tmr_writedata;
          if (tmr_writedata[3]) t_run <= 1'b0;
          else if (tmr_writedata[2]) begin t_run <= 1'b1; t_cnt <= {t_ph, t_pl}; end
        end
        3'd2: begin t_pl <= tmr_writedata; t_run <= 1'b0; t_to <= 1'b0; end
        3'd3: begin t_ph <= tmr_writedata; t_run <= 1'b0; t_to <= 1'b0; end
        default: ;
      endcase
    end
  end

  // ---------------- reference model + expected bus queue ----------------
  logic [18:0] exp_q[$];   // {address, writedata} of each expected write
  int m_t = 0;             // expected time as milliseconds of the day
  bit m_tick = 0;
  int m_ticks = 0;
  int m_secs = 0;
  bit m_alarm = 0;
  bit m_al_armed = 0;
  int m_al_minute = 0;

  // A timeout is serviced unless run is low when the sequencer sees it;
  // the count lands two clocks after the timeout, and a set load wins.
  always @(posedge clk) begin
    int h, mi, s;
    bit ticked;
    ticked = 0;
    m_tick = 0;
    if (!reset_n) begin
      m_t = 0; pend1 <= 1'b0; m_alarm = 0; m_al_armed = 0;
    end else begin
      pend1 <= pend0 && run;
      if (pend0 && run) exp_q.push_back({3'd0, 16'h0000});
      if (set_valid) begin
        h  = (set_hour > 23) ? 23 : set_hour;
        mi = (set_min > 59) ? 59 : set_min;
        s  = (set_sec > 59) ? 59 : set_sec;
        m_t = ((h * 60 + mi) * 60 + s) * 1000;
      end else if (pend1) begin
        m_t = (m_t + 1) % DAY_MS;
        m_ticks++;
        ticked = 1;
        if (m_t % 1000 == 0) begin m_tick = 1; m_secs++; end
      end
`ifdef WATCH_ALARM_EN
      if (alarm_ack) m_alarm = 0;
      else if (ticked && m_al_armed && (m_t % 60000 == 0) && (m_t / 60000 == m_al_minute))
        m_alarm = 1;
      if (alarm_set) begin
        m_al_armed = 1;
        m_al_minute = alarm_hour * 60 + alarm_min;
      end
`endif
    end
  end

  // ---------------- monitors ----------------
  bit cmp_en = 0;
  int tick_seen = 0;

  // Continuous time / tick comparison against the model.
  always @(negedge clk) begin
    if (cmp_en && reset_n) begin
      checks++;
      if (hour !== 5'(m_t / 3600000) || min !== 6'((m_t / 60000) % 60) ||
          sec !== 6'((m_t / 1000) % 60) || ms !== 10'(m_t % 1000) || tick_1s !== m_tick) begin
        errors++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL time_track: got %0d:%0d:%0d.%0d tick=%b expected %0d:%0d:%0d.%0d tick=%b",
                   hour, min, sec, ms, tick_1s, m_t / 3600000, (m_t / 60000) % 60,
                   (m_t / 1000) % 60, m_t % 1000, m_tick);
        end
      end
`ifdef WATCH_ALARM_EN
      checks++;
      if (alarm !== m_alarm) begin
        errors++;
        $display("FAIL alarm_track: got %b expected %b", alarm, m_alarm);
      end
`endif
    end
    if (reset_n && tick_1s) tick_seen++;
  end

  // Every bus write is checked in order against the expected queue.
  always @(negedge clk) begin
    logic [18:0] e;
    if (reset_n && (tmr_chipselect || !tmr_write_n)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected: got cs=%b wn=%b addr=%0d data=%h expected no write",
                 tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
      end else begin
        e = exp_q.pop_front();
        if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, e}) begin
          errors++;
          $display("FAIL bus_write: got cs=%b wn=%b addr=%0d data=%h expected addr=%0d data=%h",
                   tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, e[18:16], e[15:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_set(input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s);
    set_hour = h; set_min = mi; set_sec = s; set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  task automatic start_run();
    logic [31:0] per;
    per = PERIOD;
    exp_q.push_back({3'd2, per[15:0]});
    exp_q.push_back({3'd3, per[31:16]});
    exp_q.push_back({3'd1, 16'h0007});
    run = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL start_running_early: got %b expected 0", running);
    end
    @(negedge clk);
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL start_running: got %b expected 1", running);
    end
    clr_en = 1;
  endtask

  task automatic run_ticks(input int n);
    int target, budget;
    target = m_ticks + n;
    budget = n * 15 + 50;
    while (m_ticks < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (m_ticks < target) begin
      errors++; $display("FAIL tick_timeout: got %0d ticks expected %0d", m_ticks, target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, ms, sec, min, hour,
         tick_1s, running} !== {1'b0, 1'b1, 3'd0, 16'd0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got cs=%b wn=%b addr=%0d data=%h t=%0d:%0d:%0d.%0d run=%b",
               tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, hour, min, sec, ms, running);
    end
    reset_n = 1'b1;
    cmp_en = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_first_second();
    int t0;
    start_run();
    t0 = tick_seen;
    run_ticks(1000);
    repeat (2) @(negedge clk);
    checks++;
    if ({hour, min, sec, ms} !== {5'd0, 6'd0, 6'd1, 10'd0} || tick_seen - t0 !== 1) begin
      errors++;
      $display("FAIL first_second: got %0d:%0d:%0d.%0d ticks=%0d expected 0:0:1.0 ticks=1",
               hour, min, sec, ms, tick_seen - t0);
    end
  endtask

  task automatic test_day_wrap();
    int t0;
    do_set(5'd23, 6'd59, 6'd59);
    t0 = tick_seen;
    run_ticks(1000);
    repeat (2) @(negedge clk);
    checks++;
    if ({hour, min, sec, ms} !== {5'd0, 6'd0, 6'd0, 10'd0} || tick_seen - t0 !== 1) begin
      errors++;
      $display("FAIL day_wrap: got %0d:%0d:%0d.%0d ticks=%0d expected 0:0:0.0 ticks=1",
               hour, min, sec, ms, tick_seen - t0);
    end
  endtask

  task automatic test_random_sets();
    for (int i = 0; i < 6; i++) begin
      logic [4:0] h;
      logic [5:0] mi, s;
      int t0, s0;
      h = 5'($urandom_range(0, 31));
      mi = 6'($urandom_range(0, 63));
      s = 6'($urandom_range(0, 63));
      do_set(h, mi, s);
      checks++;
      if (hour !== ((h > 23) ? 5'd23 : h) || min !== ((mi > 59) ? 6'd59 : mi) ||
          sec !== ((s > 59) ? 6'd59 : s) || ms !== 10'd0) begin
        errors++;
        $display("FAIL set_clamp: got %0d:%0d:%0d.%0d for set %0d:%0d:%0d",
                 hour, min, sec, ms, h, mi, s);
      end
      t0 = tick_seen;
      s0 = m_secs;
      run_ticks($urandom_range(1, 1500));
      repeat (2) @(negedge clk);
      checks++;
      if (tick_seen - t0 !== m_secs - s0) begin
        errors++;
        $display("FAIL tick_count: got %0d expected %0d", tick_seen - t0, m_secs - s0);
      end
    end
  endtask

  task automatic test_set_collide();
    int budget;
    budget = 40;
    while (!(tmr_chipselect && tmr_address == 3'd0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++; $display("FAIL collide_wait: got no clear write expected one within 40 clk");
    end
    do_set(5'd12, 6'd34, 6'd56);
    checks++;
    if ({hour, min, sec, ms} !== {5'd12, 6'd34, 6'd56, 10'd0}) begin
      errors++;
      $display("FAIL set_collide: got %0d:%0d:%0d.%0d expected 12:34:56.0", hour, min, sec, ms);
    end
    run_ticks(30);
  endtask

  task automatic test_stop_on_irq();
    int budget, t_before;
    budget = 40;
    while (!tmr_irq && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++; $display("FAIL stop_wait: got no irq expected one within 40 clk");
    end
    t_before = m_t;
    exp_q.push_back({3'd1, 16'h0008});
    run = 1'b0;
    clr_en = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (running !== 1'b0 || m_t !== t_before || ms !== 10'(t_before % 1000)) begin
      errors++;
      $display("FAIL stop_discard: got running=%b ms=%0d expected running=0 ms=%0d",
               running, ms, t_before % 1000);
    end
    start_run();
    run_ticks(50);
  endtask

  task automatic test_reset_mid();
    cmp_en = 0;
    clr_en = 0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({tmr_chipselect, tmr_write_n, ms, sec, min, hour, tick_1s, running} !==
        {1'b0, 1'b1, 10'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got cs=%b wn=%b t=%0d:%0d:%0d.%0d run=%b expected all idle",
               tmr_chipselect, tmr_write_n, hour, min, sec, ms, running);
    end
`ifdef WATCH_ALARM_EN
    checks++;
    if (alarm !== 1'b0) begin
      errors++; $display("FAIL reset_alarm: got %b expected 0", alarm);
    end
`endif
    exp_q.delete();
    run = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cmp_en = 1;
    start_run();
    run_ticks(25);
  endtask

`ifdef WATCH_ALARM_EN
  task automatic test_alarm();
    alarm_hour = 5'd0; alarm_min = 6'd1; alarm_set = 1'b1;
    @(negedge clk);
    alarm_set = 1'b0;
    do_set(5'd0, 6'd0, 6'd59);
    run_ticks(1000);
    repeat (3) @(negedge clk);
    checks++;
    if (alarm !== 1'b1) begin
      errors++; $display("FAIL alarm_rise: got %b expected 1", alarm);
    end
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    checks++;
    if (alarm !== 1'b0) begin
      errors++; $display("FAIL alarm_ack: got %b expected 0", alarm);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_first_second();
    test_day_wrap();
    test_random_sets();
    test_set_collide();
    test_stop_on_irq();
`ifdef WATCH_ALARM_EN
    test_alarm();
`endif
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL bus_drain: got %0d writes outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
